// File: rtl/com_sequencer_if.sv
// Bundles the sequencer's start, node-memory, COM-unit and result signals.
// master = sequencer side, slave = memory/COM/consumer side.
interface com_sequencer_if #(
    parameter int POSITION_SIZE = 8,
    parameter int NUM_NODES     = 16,
    parameter int NUM_BODIES    = 4
);
    localparam int AW = (NUM_BODIES * NUM_NODES > 1) ? $clog2(NUM_BODIES * NUM_NODES) : 1;
    localparam int BW = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1;

    logic                     start_in;
    logic [AW-1:0]            addr_out;
    logic [POSITION_SIZE-1:0] mem_x_in;
    logic [POSITION_SIZE-1:0] mem_y_in;
    logic [POSITION_SIZE-1:0] com_x_out;
    logic [POSITION_SIZE-1:0] com_y_out;
    logic                     com_valid_out;
    logic                     com_tabulate_out;
    logic [POSITION_SIZE-1:0] com_x_in;
    logic [POSITION_SIZE-1:0] com_y_in;
    logic                     com_valid_in;
    logic [BW-1:0]            body_id_out;
    logic [POSITION_SIZE-1:0] res_x_out;
    logic [POSITION_SIZE-1:0] res_y_out;
    logic                     res_valid_out;
    logic                     done_out;
    logic                     busy_out;
    logic                     timeout_out;

    modport master (
        input  start_in, mem_x_in, mem_y_in, com_x_in, com_y_in, com_valid_in,
        output addr_out, com_x_out, com_y_out, com_valid_out, com_tabulate_out,
               body_id_out, res_x_out, res_y_out, res_valid_out, done_out,
               busy_out, timeout_out
    );

    modport slave (
        output start_in, mem_x_in, mem_y_in, com_x_in, com_y_in, com_valid_in,
        input  addr_out, com_x_out, com_y_out, com_valid_out, com_tabulate_out,
               body_id_out, res_x_out, res_y_out, res_valid_out, done_out,
               busy_out, timeout_out
    );
endinterface

// File: rtl/com_sequencer.sv
// Walks every body's nodes from node memory into center_of_mass, pulses tabulate,
// captures the COM result and reports it tagged with the body index.
module com_sequencer #(
    parameter int POSITION_SIZE = 8,
    parameter int NUM_NODES     = 16,
    parameter int NUM_BODIES    = 4,
    parameter int MEM_LATENCY   = 2,
    parameter int TIMEOUT       = 1023
) (
    input  logic clk_in,
    input  logic rst_in,
    com_sequencer_if.master bus
);
    localparam int AW = (NUM_BODIES * NUM_NODES > 1) ? $clog2(NUM_BODIES * NUM_NODES) : 1;
    localparam int BW = (NUM_BODIES > 1) ? $clog2(NUM_BODIES) : 1;
    localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int DW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DRAIN, S_TAB, S_WAIT, S_REPORT
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            body_q, body_d;
    logic [NW-1:0]            node_q, node_d;
    logic [DW-1:0]            drain_q, drain_d;
    logic [TW-1:0]            wait_q, wait_d;
    logic [MEM_LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     issue_q, issue_d;
    logic                     tab_q, tab_d;
    logic [BW-1:0]            body_id_q, body_id_d;
    logic [POSITION_SIZE-1:0] res_x_q, res_x_d;
    logic [POSITION_SIZE-1:0] res_y_q, res_y_d;
    logic                     res_vld_q, res_vld_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        body_d      = body_q;
        node_d      = node_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        issue_d     = 1'b0;
        tab_d       = 1'b0;
        body_id_d   = body_id_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        res_vld_d   = 1'b0;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        // Issue strobe delayed by the memory latency marks data valid at the COM input.
        vld_sr_d[0] = issue_q;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    state_d   = S_ISSUE;
                    body_d    = '0;
                    node_d    = '0;
                    addr_d    = '0;
                    issue_d   = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (node_q == NW'(NUM_NODES - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    node_d  = node_q + NW'(1);
                    addr_d  = addr_q + AW'(1);
                    issue_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(MEM_LATENCY - 1)) begin
                    state_d = S_TAB;
                    tab_d   = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_TAB: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (bus.com_valid_in) begin
                    state_d   = S_REPORT;
                    res_x_d   = bus.com_x_in;
                    res_y_d   = bus.com_y_in;
                    body_id_d = body_q;
                    res_vld_d = 1'b1;
                    done_d    = (body_q == BW'(NUM_BODIES - 1));
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_REPORT: begin
                if (body_q == BW'(NUM_BODIES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    // Bodies are stored back to back, so the next body's first node follows on.
                    state_d = S_ISSUE;
                    body_d  = body_q + BW'(1);
                    node_d  = '0;
                    addr_d  = addr_q + AW'(1);
                    issue_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            body_q    <= '0;
            node_q    <= '0;
            drain_q   <= '0;
            wait_q    <= '0;
            vld_sr_q  <= '0;
            addr_q    <= '0;
            issue_q   <= 1'b0;
            tab_q     <= 1'b0;
            body_id_q <= '0;
            res_x_q   <= '0;
            res_y_q   <= '0;
            res_vld_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            body_q    <= body_d;
            node_q    <= node_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            vld_sr_q  <= vld_sr_d;
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            tab_q     <= tab_d;
            body_id_q <= body_id_d;
            res_x_q   <= res_x_d;
            res_y_q   <= res_y_d;
            res_vld_q <= res_vld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.addr_out         = addr_q;
    assign bus.com_x_out        = bus.mem_x_in;
    assign bus.com_y_out        = bus.mem_y_in;
    assign bus.com_valid_out    = vld_sr_q[MEM_LATENCY-1];
    assign bus.com_tabulate_out = tab_q;
    assign bus.body_id_out      = body_id_q;
    assign bus.res_x_out        = res_x_q;
    assign bus.res_y_out        = res_y_q;
    assign bus.res_valid_out    = res_vld_q;
    assign bus.done_out         = done_q;
    assign bus.busy_out         = busy_q;
    assign bus.timeout_out      = timeout_q;
endmodule
